conf_loader: RTL
================

CONF_LOADER -- requirements
Module: conf_loader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; parameters and ports are listed below.
REQ-002 Parameter N_PE, default 16, SHALL be the number of PEs configured (4x4 array, row-major index 0..15).
REQ-003 Parameter CONF_W, default 20, SHALL be the per-PE configuration width: ALU 4 + SEL_A 3 + SEL_B 3 + SE 10.
REQ-004 CLK  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  SHALL be the synchronous active-high reset.
REQ-006 IN_WORD  input  32  SHALL carry the configuration stream word.
REQ-007 IN_VALID  input  1  SHALL indicate IN_WORD is valid.
REQ-008 IN_READY  output  1  SHALL indicate the block accepts IN_WORD this cycle; transfer = IN_VALID & IN_READY.
REQ-009 CONF_ALU_ALL  output  N_PE*4  SHALL carry the active ALU config, PE i at bits [4i+3:4i].
REQ-010 CONF_SEL_A_ALL / CONF_SEL_B_ALL  output  N_PE*3 each  SHALL carry the active operand selects, PE i at [3i+2:3i].
REQ-011 CONF_SE_ALL  output  N_PE*10  SHALL carry the active switch-element config, PE i at [10i+9:10i].
REQ-012 DONE  output  1  SHALL pulse high for exactly one cycle when a commit completes.
REQ-013 ERR  output  1  SHALL be a sticky error flag, cleared only by RST.

Function
REQ-014 Word format SHALL be: [31:28] command, [27:24] PE index, [19:0] payload {ALU[19:16], SEL_A[15:13], SEL_B[12:10], SE[9:0]}; bits [23:20] ignored.
REQ-015 Commands SHALL be HDR=4'h1 (payload[4:0] = word count K, 0..16) and CONF=4'h2; all other codes are illegal.
REQ-016 FSM SHALL have states IDLE, LOAD, COMMIT; reset state IDLE.
REQ-017 IDLE: IN_READY=1; accepted HDR with K>0 -> latch K into counter, go LOAD; HDR with K=0 -> go COMMIT directly; any other accepted word -> set ERR, stay IDLE.
REQ-018 IDLE: an accepted HDR with K>16 SHALL set ERR and stay IDLE.
REQ-019 LOAD: IN_READY=1; each accepted CONF word SHALL write its payload into the shadow register of the indexed PE and decrement the counter.
REQ-020 LOAD: an accepted non-CONF word SHALL set ERR, be discarded, and not decrement the counter.
REQ-021 LOAD: when the counter decrements to 0 on a transfer, next state SHALL be COMMIT.
REQ-022 COMMIT: IN_READY=0; for one cycle the whole shadow bank SHALL copy to the active bank; DONE=1 in the cycle after COMMIT; next state IDLE.
REQ-023 Active outputs SHALL be driven from registers only and SHALL change only on the COMMIT edge (zero glitch toward the PE array mid-load).
REQ-024 Shadow entries not written in a load SHALL retain their prior values; repeated writes to one index SHALL keep the last.
REQ-025 Latency: last CONF transfer at edge t -> COMMIT state during cycle t..t+1 -> active outputs updated at edge t+1 -> DONE high in cycle t+1..t+2.
REQ-026 IN_VALID low SHALL stall LOAD indefinitely with no state change.

Reset
REQ-027 RST SHALL clear active and shadow banks to all-zero (ALU NOP, SEL 0, SE 0), counter 0, DONE 0, ERR 0, state IDLE, IN_READY 0 while RST is high.
REQ-028 RST asserted mid-LOAD or in COMMIT SHALL abort the load with no commit and no DONE pulse.

Structure
REQ-029 Field widths, bit offsets, command codes and NOP value SHALL live in the shared header alongside the existing CONF_*_B width definitions.
REQ-030 One sub-module conf_bank (N_PE x CONF_W shadow/active register pair with write port and commit) SHALL be used; FSM and decode stay in conf_loader.

Verification
REQ-031 Reset -> all CONF_*_ALL = 0, IN_READY=0 during RST, 1 the cycle after, ERR=0.
REQ-032 HDR K=2, CONF idx3 payload 20'hA5432, CONF idx15 payload 20'h1F3FF -> DONE pulse; CONF_ALU_ALL[15:12]=4'hA, PE15 ALU=4'h1, SE=10'h3FF; others 0.
REQ-033 Same load with IN_VALID toggled every other cycle -> outputs unchanged until COMMIT edge, identical final values.
REQ-034 HDR K=1 then word cmd=4'h7 then CONF idx0 -> ERR=1, PE0 loaded, exactly one DONE.
REQ-035 HDR K=3, two CONF words, RST pulse -> active bank stays at prior values (zero), no DONE.
REQ-036 HDR K=0 -> DONE after 2 cycles, outputs equal previous shadow contents; IN_READY=0 in COMMIT cycle.

Source files
------------

// File: rtl/conf_loader_pkg.sv
// Shared definitions for the configuration loader: field widths, payload
// bit offsets, stream command codes and the FSM state encoding.
package conf_loader_pkg;

  localparam int CONF_ALU_B  = 4;
  localparam int CONF_SELA_B = 3;
  localparam int CONF_SELB_B = 3;
  localparam int CONF_SE_B   = 10;
  localparam int CONF_B      = CONF_ALU_B + CONF_SELA_B + CONF_SELB_B + CONF_SE_B;

  localparam int ALU_LSB  = 16;
  localparam int SELA_LSB = 13;
  localparam int SELB_LSB = 10;
  localparam int SE_LSB   = 0;

  localparam int WORD_B  = 32;
  localparam int CMD_LSB = 28;
  localparam int CMD_B   = 4;
  localparam int IDX_LSB = 24;
  localparam int IDX_B   = 4;
  localparam int CNT_B   = 5;

  localparam logic [CNT_B-1:0]      MAX_WORDS = 5'd16;
  localparam logic [CONF_ALU_B-1:0] ALU_NOP   = 4'h0;

  typedef enum logic [CMD_B-1:0] {
    CMD_HDR  = 4'h1,
    CMD_CONF = 4'h2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } state_e;

  // Idle configuration of one PE: ALU NOP, both selects 0, switch element 0.
  function automatic logic [CONF_B-1:0] nop_conf();
    return {ALU_NOP, {(CONF_B-CONF_ALU_B){1'b0}}};
  endfunction

endpackage

// File: rtl/conf_bank.sv
// Double-buffered per-PE configuration store: the loader writes the shadow
// bank one entry at a time, and a commit copies all of it to the active bank.
module conf_bank
  import conf_loader_pkg::*;
#(
  parameter int N_PE   = 16,
  parameter int CONF_W = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [IDX_B-1:0]         i_wr_idx,
  input  logic [CONF_W-1:0]        i_wr_data,
  input  logic                     i_commit,
  output logic [N_PE*CONF_W-1:0]   o_active
);

  logic [CONF_W-1:0] r_shadow [N_PE];
  logic [CONF_W-1:0] r_active [N_PE];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_PE; i++) begin
        r_shadow[i] <= CONF_W'(nop_conf());
        r_active[i] <= CONF_W'(nop_conf());
      end
    end else begin
      for (int i = 0; i < N_PE; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_B'(i))) begin
          r_shadow[i] <= i_wr_data;
        end
        if (i_commit) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_PE; g++) begin : g_flat
    assign o_active[g*CONF_W +: CONF_W] = r_active[g];
  end

endmodule

// File: rtl/conf_loader.sv
// Configuration stream loader: decodes HDR/CONF words into a shadow bank and
// commits the whole bank to the PE array in a single cycle.
module conf_loader
  import conf_loader_pkg::*;
#(
  parameter int N_PE   = 16,
  parameter int CONF_W = 20
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WORD_B-1:0]           IN_WORD,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [N_PE*CONF_ALU_B-1:0]  CONF_ALU_ALL,
  output logic [N_PE*CONF_SELA_B-1:0] CONF_SEL_A_ALL,
  output logic [N_PE*CONF_SELB_B-1:0] CONF_SEL_B_ALL,
  output logic [N_PE*CONF_SE_B-1:0]   CONF_SE_ALL,
  output logic                        DONE,
  output logic                        ERR
);

  state_e              r_state;
  logic [CNT_B-1:0]    r_count;
  logic                r_done;
  logic                r_err;

  logic [CMD_B-1:0]        w_cmd;
  logic [IDX_B-1:0]        w_idx;
  logic [CONF_W-1:0]       w_payload;
  logic [CNT_B-1:0]        w_k;
  logic                    w_xfer;
  logic                    w_wr_en;
  logic                    w_commit;
  logic [N_PE*CONF_W-1:0]  w_active;
  logic                    w_unused;

  assign w_cmd     = IN_WORD[CMD_LSB +: CMD_B];
  assign w_idx     = IN_WORD[IDX_LSB +: IDX_B];
  assign w_payload = IN_WORD[CONF_W-1:0];
  assign w_k       = IN_WORD[CNT_B-1:0];
  assign w_unused  = ^IN_WORD[IDX_LSB-1:CONF_B];

  assign IN_READY = ~RST & (r_state != ST_COMMIT);
  assign w_xfer   = IN_VALID & IN_READY;
  assign w_wr_en  = (r_state == ST_LOAD) & w_xfer & (w_cmd == CMD_CONF);
  assign w_commit = (r_state == ST_COMMIT);

  assign DONE = r_done;
  assign ERR  = r_err;

  // Illegal words set the sticky error and are dropped without touching the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_cmd == CMD_HDR) begin
              if (w_k == '0) begin
                r_state <= ST_COMMIT;
              end else if (w_k > MAX_WORDS) begin
                r_err <= 1'b1;
              end else begin
                r_count <= w_k;
                r_state <= ST_LOAD;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            if (w_cmd == CMD_CONF) begin
              r_count <= r_count - CNT_B'(1);
              if (r_count == CNT_B'(1)) begin
                r_state <= ST_COMMIT;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  conf_bank #(
    .N_PE   (N_PE),
    .CONF_W (CONF_W)
  ) u_bank (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx),
    .i_wr_data (w_payload),
    .i_commit  (w_commit),
    .o_active  (w_active)
  );

  for (genvar g = 0; g < N_PE; g++) begin : g_split
    assign CONF_ALU_ALL  [g*CONF_ALU_B  +: CONF_ALU_B ] = w_active[g*CONF_W + ALU_LSB  +: CONF_ALU_B ];
    assign CONF_SEL_A_ALL[g*CONF_SELA_B +: CONF_SELA_B] = w_active[g*CONF_W + SELA_LSB +: CONF_SELA_B];
    assign CONF_SEL_B_ALL[g*CONF_SELB_B +: CONF_SELB_B] = w_active[g*CONF_W + SELB_LSB +: CONF_SELB_B];
    assign CONF_SE_ALL   [g*CONF_SE_B   +: CONF_SE_B  ] = w_active[g*CONF_W + SE_LSB   +: CONF_SE_B  ];
  end

endmodule
